// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the two writeback requester handshakes and the register-file write
// port that the arbiter drives.
//
// Signals:
//   req0_valid/rd/data, req0_ready : ALU result path handshake
//   req1_valid/rd/data, req1_ready : load/multiply result path handshake
//   rf_we, rf_rd, rf_data          : registered register-file write port
//
// Modports:
//   master : requester side (drives valid/rd/data, observes ready and rf_*)
//   slave  : arbiter side (drives ready and rf_*)
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_rd;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_rd;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [DATA_WIDTH-1:0] rf_data;

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        input  rf_we, rf_rd, rf_data
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        output rf_we, rf_rd, rf_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between two writeback
// requesters using round-robin arbitration with valid/ready handshakes.
// The winning write is registered once before reaching the register file.
// Writes to register 0 are accepted but never raise rf_we.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   stall        : pipeline stall, blocks every grant while high
//   bus          : requester handshakes and register-file write port (slave)
//   commit_cnt   : number of rf_we pulses, wraps
//   conflict_cnt : cycles with at least one valid requester not granted,
//                  saturates at all-ones
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    regfile_wb_arbiter_if.slave  bus,
    output logic [CNT_WIDTH-1:0] commit_cnt,
    output logic [CNT_WIDTH-1:0] conflict_cnt
);

    // last_grant = 1 means requester 1 won most recently, so requester 0
    // takes the next tie.
    logic                  last_grant;
    logic                  grant0;
    logic                  grant1;
    logic                  xfer;
    logic                  conflict;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    // Grant selection. Readies are held low while in reset and while stalled;
    // otherwise a lone valid requester wins outright and a tie goes to the
    // requester that did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !stall) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // A grant is only ever given to a valid requester, so any grant is a
    // transfer at the next edge.
    assign xfer     = grant0 | grant1;
    assign win_rd   = grant1 ? bus.req1_rd   : bus.req0_rd;
    assign win_data = grant1 ? bus.req1_data : bus.req0_data;

    // Counts once per cycle even when both requesters are held off by stall.
    assign conflict = (bus.req0_valid && !grant0) || (bus.req1_valid && !grant1);

    // Output stage, round-robin pointer and debug counters. rf_rd/rf_data
    // capture every accepted write (including register 0) but rf_we only
    // pulses for non-zero destinations, and commit_cnt tracks those pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_rd    <= '0;
            bus.rf_data  <= '0;
            last_grant   <= 1'b1;
            commit_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            bus.rf_we <= xfer && (win_rd != '0);
            if (xfer) begin
                bus.rf_rd   <= win_rd;
                bus.rf_data <= win_data;
                last_grant  <= grant1;
            end
            if (xfer && (win_rd != '0)) begin
                commit_cnt <= commit_cnt + CNT_WIDTH'(1);
            end
            if (conflict && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. Counters are built 4 bits wide
// so wrap and saturation are reachable in a few cycles. A behavioural model
// (who won last, expected write port contents, counter values) predicts every
// observed value; each scenario task does its own comparisons.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic [CW-1:0] commit_cnt;
    logic [CW-1:0] conflict_cnt;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .bus          (bus),
        .commit_cnt   (commit_cnt),
        .conflict_cnt (conflict_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: which requester was accepted most recently and what the
    // register-file port and counters ought to show.
    int        lastWinner;
    bit        mWe;
    bit [4:0]  mRd;
    bit [31:0] mData;
    int        mCommit;
    int        mConflict;

    task automatic model_reset();
        lastWinner = 1;
        mWe        = 0;
        mRd        = 0;
        mData      = 0;
        mCommit    = 0;
        mConflict  = 0;
    endtask

    // Which requester should be granted right now: -1 for none.
    function automatic int expWinner();
        if (!rst_n || stall) return -1;
        if (bus.req0_valid && bus.req1_valid) return 1 - lastWinner;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    // Advance one rising edge and update the model from the pre-edge inputs;
    // returns 1 ns after the edge so outputs can be sampled.
    task automatic tick();
        int w;
        bit starved;
        bit [4:0] rd;
        w = expWinner();
        starved = (bus.req0_valid && w != 0) || (bus.req1_valid && w != 1);
        rd = (w == 1) ? bus.req1_rd : bus.req0_rd;
        @(posedge clk);
        if (w >= 0) begin
            mRd        = rd;
            mData      = (w == 1) ? bus.req1_data : bus.req0_data;
            mWe        = (rd != 0);
            lastWinner = w;
            if (mWe) mCommit = (mCommit + 1) % (CMAX + 1);
        end else begin
            mWe = 0;
        end
        if (starved && mConflict < CMAX) mConflict++;
        #1;
    endtask

    // Hold reset across two edges with idle inputs, release after a falling edge.
    task automatic do_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_rd    = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_rd    = '0;
        bus.req1_data  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset state, with readies held low in reset even when a requester is valid.
    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_rd = 5'd3;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready0: got %b expected 0", bus.req0_ready);
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_data !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_rf: got we=%b rd=%0d data=%h expected 0/0/0",
                               bus.rf_we, bus.rf_rd, bus.rf_data);
        end
        checks++;
        if (commit_cnt !== 4'd0 || conflict_cnt !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_counters: got commit=%0d conflict=%0d expected 0/0",
                               commit_cnt, conflict_cnt);
        end
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
        end
    endtask

    // A lone requester is granted in the same cycle; the write appears one edge later.
    task automatic test_single();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd5;
        bus.req0_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL single_ready: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_data !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL single_write: got we=%b rd=%0d data=%h expected 1/5/deadbeef",
                               bus.rf_we, bus.rf_rd, bus.rf_data);
        end
        checks++;
        if (commit_cnt !== 4'd1) begin
            errors++; $display("[TB] FAIL single_commit: got %0d expected 1", commit_cnt);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd5 || bus.rf_data !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL single_hold: got we=%b rd=%0d data=%h expected 0/5/deadbeef",
                               bus.rf_we, bus.rf_rd, bus.rf_data);
        end
    endtask

    // Both requesters valid for four cycles: grants alternate starting with 0.
    task automatic test_round_robin();
        int expGrant[4] = '{0, 1, 0, 1};
        int expRd[4]    = '{1, 2, 1, 2};
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd1;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd2;
        for (int i = 0; i < 4; i++) begin
            bus.req0_data = 32'h100 + i;
            bus.req1_data = 32'h200 + i;
            #1;
            checks++;
            if (bus.req0_ready !== (expGrant[i] == 0) || bus.req1_ready !== (expGrant[i] == 1)) begin
                errors++; $display("[TB] FAIL rr_grant[%0d]: got %b%b expected requester %0d",
                                   i, bus.req0_ready, bus.req1_ready, expGrant[i]);
            end
            tick();
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(expRd[i])) begin
                errors++; $display("[TB] FAIL rr_rd[%0d]: got we=%b rd=%0d expected 1/%0d",
                                   i, bus.rf_we, bus.rf_rd, expRd[i]);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++;
        if (conflict_cnt !== 4'd4 || commit_cnt !== 4'd4) begin
            errors++; $display("[TB] FAIL rr_counters: got conflict=%0d commit=%0d expected 4/4",
                               conflict_cnt, commit_cnt);
        end
    endtask

    // A write to register 0 is accepted but produces no write enable.
    task automatic test_reg_zero();
        do_reset();
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd0;
        bus.req1_data  = 32'h1234;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL zero_ready: got %b expected 1", bus.req1_ready);
        end
        tick();
        bus.req1_valid = 1'b0;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_data !== 32'h1234 || commit_cnt !== 4'd0) begin
            errors++; $display("[TB] FAIL zero_write: got we=%b rd=%0d data=%h commit=%0d expected 0/0/1234/0",
                               bus.rf_we, bus.rf_rd, bus.rf_data, commit_cnt);
        end
    endtask

    // Stall blocks the grant and counts a conflict each cycle; release completes the write.
    task automatic test_stall();
        do_reset();
        stall          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd7;
        bus.req0_data  = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.req0_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", i, bus.req0_ready);
            end
            tick();
            checks++;
            if (bus.rf_we !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_we[%0d]: got %b expected 0", i, bus.rf_we);
            end
        end
        checks++;
        if (conflict_cnt !== 4'd3) begin
            errors++; $display("[TB] FAIL stall_conflict: got %0d expected 3", conflict_cnt);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_release_ready: got %b expected 1", bus.req0_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_data !== 32'hA5A5A5A5 || conflict_cnt !== 4'd3) begin
            errors++; $display("[TB] FAIL stall_release_write: got we=%b rd=%0d data=%h conflict=%0d expected 1/7/a5a5a5a5/3",
                               bus.rf_we, bus.rf_rd, bus.rf_data, conflict_cnt);
        end
    endtask

    // Reset asserted while rf_we is high drops it at once, loses the pending
    // transfer, and restores requester 0 as the tie winner.
    task automatic test_reset_mid();
        do_reset();
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd9;
        bus.req1_data  = 32'h99;
        tick();
        checks++;
        if (bus.rf_we !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_pre_we: got %b expected 1", bus.rf_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.req1_ready !== 1'b0 || commit_cnt !== 4'd0) begin
            errors++; $display("[TB] FAIL mid_async: got we=%b ready1=%b commit=%0d expected 0/0/0",
                               bus.rf_we, bus.req1_ready, commit_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0) begin
            errors++; $display("[TB] FAIL mid_lost: got we=%b rd=%0d expected 0/0", bus.rf_we, bus.rf_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd3;
        bus.req0_data  = 32'h33;
        bus.req1_rd    = 5'd4;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_tie: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++;
        if (bus.rf_rd !== 5'd3 || bus.rf_data !== 32'h33) begin
            errors++; $display("[TB] FAIL mid_tie_write: got rd=%0d data=%h expected 3/33", bus.rf_rd, bus.rf_data);
        end
    endtask

    // Back-to-back writes wrap commit_cnt; a long stall saturates conflict_cnt.
    task automatic test_counters();
        do_reset();
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.req0_rd   = 5'(1 + (i % 31));
            bus.req0_data = 32'hC000 + i;
            tick();
            checks++;
            if (bus.rf_we !== 1'b1 || commit_cnt !== 4'((i + 1) % 16)) begin
                errors++; $display("[TB] FAIL b2b[%0d]: got we=%b commit=%0d expected 1/%0d",
                                   i, bus.rf_we, commit_cnt, (i + 1) % 16);
            end
        end
        do_reset();
        stall          = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (conflict_cnt !== 4'((i + 1 < CMAX) ? i + 1 : CMAX)) begin
                errors++; $display("[TB] FAIL sat[%0d]: got %0d expected %0d",
                                   i, conflict_cnt, (i + 1 < CMAX) ? i + 1 : CMAX);
            end
        end
        stall = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Random traffic: requesters hold their request until accepted, stall
    // toggles randomly, every cycle is compared against the model.
    task automatic test_random();
        int w;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!bus.req0_valid && $urandom_range(0, 1) == 1) begin
                bus.req0_valid = 1'b1;
                bus.req0_rd    = 5'($urandom_range(0, 31));
                bus.req0_data  = $urandom;
            end
            if (!bus.req1_valid && $urandom_range(0, 1) == 1) begin
                bus.req1_valid = 1'b1;
                bus.req1_rd    = 5'($urandom_range(0, 31));
                bus.req1_data  = $urandom;
            end
            stall = ($urandom_range(0, 4) == 0);
            #1;
            w = expWinner();
            checks++;
            if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1)) begin
                errors++; $display("[TB] FAIL rand_ready[%0d]: got %b%b expected winner %0d",
                                   c, bus.req0_ready, bus.req1_ready, w);
            end
            tick();
            checks++;
            if (bus.rf_we !== mWe || bus.rf_rd !== mRd || bus.rf_data !== mData) begin
                errors++; $display("[TB] FAIL rand_rf[%0d]: got we=%b rd=%0d data=%h expected %b/%0d/%h",
                                   c, bus.rf_we, bus.rf_rd, bus.rf_data, mWe, mRd, mData);
            end
            checks++;
            if (commit_cnt !== 4'(mCommit) || conflict_cnt !== 4'(mConflict)) begin
                errors++; $display("[TB] FAIL rand_cnt[%0d]: got commit=%0d conflict=%0d expected %0d/%0d",
                                   c, commit_cnt, conflict_cnt, mCommit, mConflict);
            end
            if (w == 0) bus.req0_valid = 1'b0;
            if (w == 1) bus.req1_valid = 1'b0;
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        $display("[TB] regfile_wb_arbiter bench start");
        test_reset();
        test_single();
        test_round_robin();
        test_reg_zero();
        test_stall();
        test_reset_mid();
        test_counters();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
